// File: rtl/pe_sequencer.sv
// Sequencer feeding a single dot-product PE: loads weights into a ping-pong
// SRAM bank, streams inputs with one-cycle-delayed weight reads, captures the result.
module pe_sequencer #(
  parameter int WEIGHT_BIT = 32,
  parameter int VEC_LEN    = 16,
  parameter int ADDR_W     = $clog2(VEC_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  reuse_weights,
  input  logic                  w_valid,
  input  logic [WEIGHT_BIT-1:0] w_data,
  output logic                  w_ready,
  input  logic                  x_valid,
  input  logic [WEIGHT_BIT-1:0] x_data,
  output logic                  x_ready,
  output logic [WEIGHT_BIT-1:0] pe_weight,
  output logic [WEIGHT_BIT-1:0] pe_input_data,
  output logic                  pe_demux_select,
  output logic                  pe_mux_select,
  output logic                  pe_write_enable,
  output logic                  pe_read_enable,
  output logic [ADDR_W-1:0]     pe_addr,
  output logic                  pe_clear,
  input  logic [WEIGHT_BIT-1:0] pe_out,
  output logic                  out_valid,
  output logic [WEIGHT_BIT-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, RUN, TAIL, OUT} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(VEC_LEN - 1);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic                    rd_issued_q, rd_issued_d;
  logic                    load_bank_q, load_bank_d;
  logic                    run_bank_q, run_bank_d;
  logic                    bank_loaded_q, bank_loaded_d;
  logic [WEIGHT_BIT-1:0]   out_data_q, out_data_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rd_addr_q     <= '0;
      rd_issued_q   <= 1'b0;
      load_bank_q   <= 1'b0;
      run_bank_q    <= 1'b0;
      bank_loaded_q <= 1'b0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_addr_q     <= rd_addr_d;
      rd_issued_q   <= rd_issued_d;
      load_bank_q   <= load_bank_d;
      run_bank_q    <= run_bank_d;
      bank_loaded_q <= bank_loaded_d;
      out_data_q    <= out_data_d;
    end
  end

  // Ready/valid depend on state only, never on the incoming valids.
  assign w_ready         = (state_q == LOAD);
  assign x_ready         = (state_q == RUN);
  assign out_valid       = (state_q == OUT);
  assign busy            = (state_q != IDLE);
  assign out_data        = out_data_q;
  assign pe_mux_select   = run_bank_q;
  assign pe_demux_select = load_bank_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rd_addr_d       = rd_addr_q;
    rd_issued_d     = rd_issued_q;
    load_bank_d     = load_bank_q;
    run_bank_d      = run_bank_q;
    bank_loaded_d   = bank_loaded_q;
    out_data_d      = out_data_q;
    pe_write_enable = 1'b0;
    pe_read_enable  = 1'b0;
    pe_clear        = 1'b0;
    pe_addr         = '0;
    pe_weight       = '0;
    pe_input_data   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = (reuse_weights && bank_loaded_q) ? CLEAR : LOAD;
        end
      end
      LOAD: begin
        if (w_valid) begin
          pe_write_enable = 1'b1;
          pe_addr         = cnt_q;
          pe_weight       = w_data;
          cnt_d           = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST) begin
            state_d       = CLEAR;
            run_bank_d    = load_bank_q;
            load_bank_d   = ~load_bank_q;
            bank_loaded_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        pe_clear    = 1'b1;
        cnt_d       = '0;
        rd_addr_d   = '0;
        rd_issued_d = 1'b0;
        state_d     = RUN;
      end
      RUN: begin
        // Weight read lags its input by one cycle; after a bubble it repeats
        // the last address while the registered input is zero.
        pe_read_enable = rd_issued_q;
        pe_addr        = rd_addr_q;
        if (x_valid) begin
          pe_input_data = x_data;
          rd_addr_d     = cnt_q;
          rd_issued_d   = 1'b1;
          cnt_d         = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST) begin
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        pe_read_enable = 1'b1;
        pe_addr        = LAST;
        out_data_d     = pe_out;
        state_d        = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
